// File: rtl/piso_8_bit.sv
// 8-bit parallel-in / serial-out shifter with a three-state frame controller.
// A frame is 8 enabled edges long; outputs are all registered.
module piso_8_bit #(
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [7:0] din,
    output logic       data,
    output logic       ready,
    output logic       busy,
    output logic       done
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                data_q, data_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Next-state, shift register, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // Enable is ignored on the accepting edge.
                if (load) begin
                    sr_d    = din;
                    cnt_d   = CNT_W'(0);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Loads arriving here are dropped; only enable advances the frame.
                if (enable) begin
                    if (MSB_FIRST) begin
                        sr_d = {sr_q[DATA_W-2:0], 1'b0};
                    end else begin
                        sr_d = {1'b0, sr_q[DATA_W-1:1]};
                    end
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid right after the edge.
        if (state_d == SHIFT) begin
            data_d = MSB_FIRST ? sr_d[DATA_W-1] : sr_d[0];
        end else begin
            data_d = IDLE_LEVEL;
        end
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data  = data_q;
    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_piso_8_bit.sv
// Scoreboard bench for piso_8_bit: frames push their expected bit order,
// a negedge monitor pops and compares bits, done markers and loopback words.
module tb_piso_8_bit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       load_m = 1'b0;
    logic       load_l = 1'b0;
    logic [7:0] din = 8'h00;

    logic data_m, ready_m, busy_m, done_m;
    logic data_l, ready_l, busy_l, done_l;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected serial stream per instance: 0/1 = bit, 2 = done marker.
    int         q_m[$];
    int         q_l[$];
    logic [7:0] wq_m[$];
    logic [7:0] wq_l[$];
    logic [7:0] sipo_m = 8'h00;
    logic [7:0] sipo_l = 8'h00;

    // MSB-first, idle-low instance (defaults).
    piso_8_bit dut_m (
        .clk(clk), .reset(reset), .enable(enable), .load(load_m), .din(din),
        .data(data_m), .ready(ready_m), .busy(busy_m), .done(done_m)
    );

    // LSB-first, idle-high instance.
    piso_8_bit #(.MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
        .clk(clk), .reset(reset), .enable(enable), .load(load_l), .din(din),
        .data(data_l), .ready(ready_l), .busy(busy_l), .done(done_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_one(input bit sel);
        logic       d, b, dn, idle;
        bit         have, whave;
        int         front;
        logic [7:0] wexp;
        d     = sel ? data_l : data_m;
        b     = sel ? busy_l : busy_m;
        dn    = sel ? done_l : done_m;
        idle  = sel ? 1'b1 : 1'b0;
        have  = sel ? (q_l.size() > 0) : (q_m.size() > 0);
        front = have ? (sel ? q_l[0] : q_m[0]) : -1;
        if (dn) begin
            check(sel ? "l_done_expected" : "m_done_expected", 8'(front == 2), 8'd1);
            check(sel ? "l_done_data_idle" : "m_done_data_idle", 8'(d), 8'(idle));
            check(sel ? "l_done_busy" : "m_done_busy", 8'(b), 8'd0);
            if (have) begin
                if (sel) void'(q_l.pop_front()); else void'(q_m.pop_front());
            end
            whave = sel ? (wq_l.size() > 0) : (wq_m.size() > 0);
            check(sel ? "l_word_queued" : "m_word_queued", 8'(whave), 8'd1);
            if (whave) begin
                wexp = sel ? wq_l.pop_front() : wq_m.pop_front();
                check(sel ? "l_loopback" : "m_loopback", sel ? sipo_l : sipo_m, wexp);
            end
        end else if (b) begin
            check(sel ? "l_bit_expected" : "m_bit_expected", 8'(have && front != 2), 8'd1);
            if (have && front < 2) begin
                check(sel ? "l_data" : "m_data", 8'(d), 8'(front[0]));
                if (enable) begin
                    if (sel) begin
                        void'(q_l.pop_front());
                        sipo_l = {d, sipo_l[7:1]};
                    end else begin
                        void'(q_m.pop_front());
                        sipo_m = {sipo_m[6:0], d};
                    end
                end
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_one(1'b0);
                mon_one(1'b1);
            end
        end
    endtask

    task automatic set_load(input bit sel, input logic v);
        if (sel) load_l = v; else load_m = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_data"}, 8'(data_m), 8'd0);
        check({tag, "_m_ready"}, 8'(ready_m), 8'd1);
        check({tag, "_m_busy"}, 8'(busy_m), 8'd0);
        check({tag, "_m_done"}, 8'(done_m), 8'd0);
        check({tag, "_l_data"}, 8'(data_l), 8'd1);
        check({tag, "_l_ready"}, 8'(ready_l), 8'd1);
    endtask

    // order: transmission order, leftmost bit first (hand-computed).
    task automatic frame(input bit sel, input logic [7:0] w, input logic [7:0] order,
                         input bit toggle, input int exp_k, input int inject_k,
                         input int abort_k);
        int t;
        int k;
        bit seen;
        t = 0;
        while (!(sel ? ready_l : ready_m) && t < 50) begin
            @(posedge clk); #1; t++;
        end
        check("ready_before_load", 8'(sel ? ready_l : ready_m), 8'd1);
        for (int i = 7; i >= 0; i--) begin
            if (sel) q_l.push_back(int'(order[i])); else q_m.push_back(int'(order[i]));
        end
        if (sel) begin q_l.push_back(2); wq_l.push_back(w); end
        else     begin q_m.push_back(2); wq_m.push_back(w); end

        din = w; set_load(sel, 1'b1); enable = 1'b1;
        @(posedge clk); #1;
        set_load(sel, 1'b0); din = ~w;
        check("busy_after_accept", 8'(sel ? busy_l : busy_m), 8'd1);
        k = 0; seen = 0;
        while (!seen && k < 40) begin
            enable = toggle ? ~enable : 1'b1;
            if (k == inject_k) begin set_load(sel, 1'b1); din = 8'hFF; end
            else set_load(sel, 1'b0);
            if (k == abort_k) begin
                #2 reset = 1'b0;
                #1 check_reset_outputs("abort");
                q_m.delete(); wq_m.delete(); q_l.delete(); wq_l.delete();
                @(posedge clk); #1;
                check_reset_outputs("abort_held");
                #2 reset = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    check("abort_no_done", 8'(done_m), 8'd0);
                end
                return;
            end
            @(posedge clk); #1; k++;
            if (k == inject_k + 1) check("ready_low_in_frame", 8'(sel ? ready_l : ready_m), 8'd0);
            if (sel ? done_l : done_m) seen = 1;
        end
        set_load(sel, 1'b0);
        check("done_latency", 8'(k), 8'(exp_k));
        enable = 1'b0;
        @(posedge clk); #1;
        check("ready_after_done", 8'(sel ? ready_l : ready_m), 8'd1);
        check("done_single_cycle", 8'(sel ? done_l : done_m), 8'd0);
        check("idle_busy", 8'(sel ? busy_l : busy_m), 8'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        #12 check_reset_outputs("reset");
        #6 reset = 1'b1;
        @(posedge clk); #1;

        frame(1'b0, 8'hA5, 8'b10100101, 1'b0, 8,  -1, -1);
        frame(1'b0, 8'hA5, 8'b10100101, 1'b1, 16, -1, -1);
        frame(1'b1, 8'h01, 8'b10000000, 1'b0, 8,  -1, -1);
        frame(1'b0, 8'h00, 8'b00000000, 1'b0, 8,   3, -1);
        frame(1'b0, 8'h5A, 8'b01011010, 1'b0, 8,  -1, -1);
        frame(1'b0, 8'hFF, 8'b11111111, 1'b0, 8,  -1, -1);
        frame(1'b0, 8'hC3, 8'b11000011, 1'b0, 8,  -1,  4);
        frame(1'b0, 8'h3C, 8'b00111100, 1'b0, 8,  -1, -1);
        frame(1'b1, 8'h0F, 8'b11110000, 1'b1, 16, -1, -1);

        repeat (3) @(posedge clk);
        #1;
        check("m_queue_drained", 8'(q_m.size() + wq_m.size()), 8'd0);
        check("l_queue_drained", 8'(q_l.size() + wq_l.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piso_8_bit.md
PISO_8_BIT -- requirements
Module: piso_8_bit

Interface
REQ-001 Parameter MSB_FIRST, default 1, meaning: 1 = bit 7 shifted out first, 0 = bit 0 first.
REQ-002 Parameter IDLE_LEVEL, default 0, meaning: value driven on data when no frame is in progress.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port enable  input  1  shift strobe; one bit advances per rising edge with enable=1.
REQ-006 Port load  input  1  request to start a frame with din.
REQ-007 Port din  input  8  parallel word to serialize.
REQ-008 Port data  output  1  registered serial bit stream.
REQ-009 Port ready  output  1  high only in IDLE; load is accepted only when ready=1.
REQ-010 Port busy  output  1  high in SHIFT state.
REQ-011 Port done  output  1  single-cycle pulse marking frame completion.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: load=1 at rising edge -> capture din into 8-bit shift register, bit counter := 0, go to SHIFT; enable in that cycle is ignored.
REQ-014 SHIFT: data SHALL equal sr[7] (MSB_FIRST=1) or sr[0] (MSB_FIRST=0), registered, valid from the first clock after load acceptance.
REQ-015 SHIFT, enable=1 at edge: shift register shifts one position toward the output end (fill with 0), counter increments; enable=0: register, counter, data hold.
REQ-016 SHIFT, enable=1 with counter=7: go to DONE; data := IDLE_LEVEL.
REQ-017 Each bit SHALL remain on data for exactly the cycles up to and including the first edge with enable=1; frame length = 8 enabled edges regardless of enable duty cycle.
REQ-018 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-019 load while busy=1 or in DONE SHALL be ignored with no effect on the frame in progress; din is sampled only at acceptance.
REQ-020 Counter is 3 bits, wraps to 0 only via new load; no partial frames except via reset.
REQ-021 IDLE/DONE: data=IDLE_LEVEL, busy=0; ready=0 in SHIFT and DONE.

Reset
REQ-022 reset=0 SHALL immediately, independent of clk, force state=IDLE, shift register=8'h00, counter=0, data=IDLE_LEVEL, ready=1, busy=0, done=0.
REQ-023 reset assertion mid-frame SHALL abort the frame with no done pulse; first load after reset release starts a fresh frame.
REQ-024 Operation resumes on the first rising edge after reset returns to 1.

Verification
REQ-025 enable held 1, load din=8'hA5 (MSB_FIRST=1) -> data = 1,0,1,0,0,1,0,1 on the 8 cycles after acceptance, done pulse on cycle 9, ready=1 on cycle 10.
REQ-026 enable toggling every cycle (50% duty), din=8'hA5 -> each bit held 2 cycles, same bit order, done after 8 enabled edges (~16 cycles).
REQ-027 MSB_FIRST=0, din=8'h01, enable=1 -> data = 1,0,0,0,0,0,0,0 then done.
REQ-028 load asserted with din=8'hFF at bit 3 of an 8'h00 frame -> frame completes as all zeros, 8'hFF never appears, ready stays 0 until IDLE.
REQ-029 reset driven 0 between clock edges at bit 4 -> outputs reach reset values before next edge, no done pulse; next load 8'h3C transmits 0,0,1,1,1,1,0,0.
REQ-030 Loopback into an 8-bit serial-in shift register clocked with the same enable -> its parallel output equals din (8'hA5, 8'h5A, 8'h00, 8'hFF) at done.
